// File: rtl/dma_priority_arb.sv
// NUM_CH-channel DMA request arbiter: DREQ conditioning, fixed/rotating priority, HRQ/HLDA handshake, one-hot DACK.
// Define DMA_DREQ_SYNC2_EN to add a second DREQ synchroniser stage (one extra cycle of DREQ-to-HRQ latency).
module dma_priority_arb #(
    parameter int  NUM_CH = 4,
    localparam int CHW    = $clog2(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic              HLDA,
    input  logic              dreq_active_low,
    input  logic              dack_active_low,
    input  logic              rotate_en,
    input  logic              ctrl_disable,
    input  logic [NUM_CH-1:0] mask,
    input  logic [NUM_CH-1:0] sw_req,
    input  logic              svc_done,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic              grant_valid,
    output logic [CHW-1:0]    grant_ch,
    output logic [NUM_CH-1:0] sw_req_clr
);

    typedef enum logic [1:0] {IDLE, HOLD_REQ, SERVICE, RELEASE} state_t;

    state_t            state_q, state_d;
    logic              hrq_q, hrq_d;
    logic              gv_q, gv_d;
    logic [NUM_CH-1:0] ack_q, ack_d;
    logic [NUM_CH-1:0] clr_q, clr_d;
    logic [CHW-1:0]    gch_q, gch_d;
    logic [CHW-1:0]    ptr_q, ptr_d;
    logic [NUM_CH-1:0] dreq_q;
    logic [NUM_CH-1:0] pending;
    logic              any_pending;
    logic [CHW-1:0]    eff_ptr;
    logic [CHW-1:0]    winner;
    logic [CHW-1:0]    next_ptr;
    logic              found;
    int                scan_idx;

    // Polarity is normalised before the synchroniser so dreq_q is always active-high.
`ifdef DMA_DREQ_SYNC2_EN
    logic [NUM_CH-1:0] dreq_meta;
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            dreq_meta <= '0;
            dreq_q    <= '0;
        end else begin
            dreq_meta <= DREQ ^ {NUM_CH{dreq_active_low}};
            dreq_q    <= dreq_meta;
        end
    end
`else
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) dreq_q <= '0;
        else          dreq_q <= DREQ ^ {NUM_CH{dreq_active_low}};
    end
`endif

    assign pending     = (dreq_q | sw_req) & ~mask & {NUM_CH{~ctrl_disable}};
    assign any_pending = |pending;
    assign eff_ptr     = rotate_en ? ptr_q : '0;
    assign next_ptr    = (int'(gch_q) == NUM_CH - 1) ? '0 : gch_q + 1'b1;

    // Scan upward from the priority pointer with wrap-around; first pending channel wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        winner   = '0;
        found    = 1'b0;
        scan_idx = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            scan_idx = (int'(eff_ptr) + k) % NUM_CH;
            if (!found && pending[scan_idx]) begin
                found  = 1'b1;
                winner = CHW'(scan_idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        hrq_d   = hrq_q;
        gv_d    = gv_q;
        ack_d   = ack_q;
        gch_d   = gch_q;
        clr_d   = '0;
        ptr_d   = rotate_en ? ptr_q : '0;
        case (state_q)
            IDLE: begin
                if (any_pending) begin
                    hrq_d   = 1'b1;
                    state_d = HOLD_REQ;
                end
            end
            HOLD_REQ: begin
                if (!any_pending) begin
                    hrq_d   = 1'b0;
                    state_d = HLDA ? RELEASE : IDLE;
                end else if (HLDA) begin
                    gch_d         = winner;
                    ack_d         = '0;
                    ack_d[winner] = 1'b1;
                    gv_d          = 1'b1;
                    state_d       = SERVICE;
                end
            end
            SERVICE: begin
                // svc_done is checked first so it wins over a simultaneous HLDA drop.
                if (svc_done) begin
                    ack_d        = '0;
                    gv_d         = 1'b0;
                    hrq_d        = 1'b0;
                    clr_d[gch_q] = 1'b1;
                    if (rotate_en) ptr_d = next_ptr;
                    state_d      = RELEASE;
                end else if (!HLDA) begin
                    ack_d   = '0;
                    gv_d    = 1'b0;
                    hrq_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            RELEASE: begin
                hrq_d = 1'b0;
                if (!HLDA) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!RESET_N) begin
            state_q <= IDLE;
            hrq_q   <= 1'b0;
            gv_q    <= 1'b0;
            ack_q   <= '0;
            gch_q   <= '0;
            clr_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            hrq_q   <= hrq_d;
            gv_q    <= gv_d;
            ack_q   <= ack_d;
            gch_q   <= gch_d;
            clr_q   <= clr_d;
            ptr_q   <= ptr_d;
        end
    end

    assign HRQ         = hrq_q;
    assign DACK        = ack_q ^ {NUM_CH{dack_active_low}};
    assign grant_valid = gv_q;
    assign grant_ch    = gch_q;
    assign sw_req_clr  = clr_q;

endmodule
